// File: rtl/pcie_us_msix_if.sv
// MSI-X request bridge: takes one address/data interrupt from the core, presents it to the
// UltraScale PCIe hard IP cfg_interrupt_msix_* port, and returns a completion status.
module pcie_us_msix_if #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [3:0]  FUNC_NUM       = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] s_axis_irq_addr,
  input  logic [31:0] s_axis_irq_data,
  input  logic        s_axis_irq_valid,
  output logic        s_axis_irq_ready,
  output logic [1:0]  m_axis_irq_status,
  output logic        m_axis_irq_status_valid,
  input  logic        m_axis_irq_status_ready,
  input  logic [1:0]  cfg_interrupt_msix_enable,
  input  logic [1:0]  cfg_interrupt_msix_mask,
  output logic [63:0] cfg_interrupt_msix_address,
  output logic [31:0] cfg_interrupt_msix_data,
  output logic        cfg_interrupt_msix_int,
  input  logic        cfg_interrupt_msix_sent,
  input  logic        cfg_interrupt_msix_fail,
  output logic [3:0]  cfg_interrupt_msi_function_number
);

  typedef enum logic [2:0] {StIdle, StPend, StIssue, StWait, StStatus} state_e;

  localparam logic [1:0] StsSent    = 2'b00;
  localparam logic [1:0] StsFail    = 2'b01;
  localparam logic [1:0] StsTimeout = 2'b10;
  localparam logic [1:0] StsDropped = 2'b11;

  // Counter holds TIMEOUT_CYCLES-1 during the int cycle and counts down through WAIT, so the
  // status appears exactly TIMEOUT_CYCLES cycles after the int strobe.
  localparam logic [15:0] CntLoad = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  code_q, code_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, int_q, status_valid_q;
  logic        accept;
  logic        msix_en, msix_mask;
  logic        unused_cfg;

  assign msix_en    = cfg_interrupt_msix_enable[0];
  assign msix_mask  = cfg_interrupt_msix_mask[0];
  assign unused_cfg = ^{cfg_interrupt_msix_enable[1], cfg_interrupt_msix_mask[1]};
  assign accept     = s_axis_irq_valid & ready_q;

  // Next-state, latched request, status code and timeout counter.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = s_axis_irq_addr;
          data_d = s_axis_irq_data;
          if (!msix_en) begin
            state_d = StStatus;
            code_d  = StsDropped;
          end else if (msix_mask) begin
            state_d = StPend;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StPend: begin
        // Disable outranks unmask.
        if (!msix_en) begin
          state_d = StStatus;
          code_d  = StsDropped;
        end else if (!msix_mask) begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (cfg_interrupt_msix_fail) begin
          state_d = StStatus;
          code_d  = StsFail;
        end else if (cfg_interrupt_msix_sent) begin
          state_d = StStatus;
          code_d  = StsSent;
        end else if (cnt_q == 16'd0) begin
          state_d = StStatus;
          code_d  = StsTimeout;
        end
      end
      StStatus: begin
        if (m_axis_irq_status_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIssue) begin
      cnt_d = CntLoad;
    end else if ((state_q == StIssue || state_q == StWait) && cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // State and registered outputs; reset clears everything and drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      code_q         <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      ready_q        <= 1'b0;
      int_q          <= 1'b0;
      status_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      code_q         <= code_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      ready_q        <= (state_d == StIdle);
      int_q          <= (state_d == StIssue);
      status_valid_q <= (state_d == StStatus);
    end
  end

  assign s_axis_irq_ready                  = ready_q;
  assign m_axis_irq_status                 = code_q;
  assign m_axis_irq_status_valid           = status_valid_q;
  assign cfg_interrupt_msix_address        = addr_q;
  assign cfg_interrupt_msix_data           = data_q;
  assign cfg_interrupt_msix_int            = int_q;
  assign cfg_interrupt_msi_function_number = FUNC_NUM;

endmodule

// File: tb/tb_pcie_us_msix_if.sv
// Self-checking bench for pcie_us_msix_if against a transaction-level outcome model.
module tb_pcie_us_msix_if;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_axis_irq_addr = '0;
  logic [31:0] s_axis_irq_data = '0;
  logic        s_axis_irq_valid = 1'b0;
  logic        s_axis_irq_ready;
  logic [1:0]  m_axis_irq_status;
  logic        m_axis_irq_status_valid;
  logic        m_axis_irq_status_ready = 1'b0;
  logic [1:0]  cfg_interrupt_msix_enable = 2'b00;
  logic [1:0]  cfg_interrupt_msix_mask = 2'b00;
  logic [63:0] cfg_interrupt_msix_address;
  logic [31:0] cfg_interrupt_msix_data;
  logic        cfg_interrupt_msix_int;
  logic        cfg_interrupt_msix_sent = 1'b0;
  logic        cfg_interrupt_msix_fail = 1'b0;
  logic [3:0]  cfg_interrupt_msi_function_number;

  int n_checks = 0;
  int n_pass = 0;

  pcie_us_msix_if #(.TIMEOUT_CYCLES(T), .FUNC_NUM(4'd0)) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .s_axis_irq_addr                   (s_axis_irq_addr),
    .s_axis_irq_data                   (s_axis_irq_data),
    .s_axis_irq_valid                  (s_axis_irq_valid),
    .s_axis_irq_ready                  (s_axis_irq_ready),
    .m_axis_irq_status                 (m_axis_irq_status),
    .m_axis_irq_status_valid           (m_axis_irq_status_valid),
    .m_axis_irq_status_ready           (m_axis_irq_status_ready),
    .cfg_interrupt_msix_enable         (cfg_interrupt_msix_enable),
    .cfg_interrupt_msix_mask           (cfg_interrupt_msix_mask),
    .cfg_interrupt_msix_address        (cfg_interrupt_msix_address),
    .cfg_interrupt_msix_data           (cfg_interrupt_msix_data),
    .cfg_interrupt_msix_int            (cfg_interrupt_msix_int),
    .cfg_interrupt_msix_sent           (cfg_interrupt_msix_sent),
    .cfg_interrupt_msix_fail           (cfg_interrupt_msix_fail),
    .cfg_interrupt_msi_function_number (cfg_interrupt_msi_function_number)
  );

  always #5 clk = ~clk;

  // Cycle offsets are counted from the cycle right after the accepting edge (c = 0).
  typedef struct {
    int          ints;
    int          int_cyc;
    int          st_cyc;
    logic [1:0]  code;
    logic [63:0] a_seen;
    logic [31:0] d_seen;
    bit          addr_ok;
    bit          stable;
    bit          got_status;
    int          rdy_cyc;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of one request, from the behavioural rules only.
  function automatic obs_t ref_model(bit en0, bit mask0, int unmask_at, int disable_at,
                                     int resp_at, bit rsent, bit rfail);
    obs_t e;
    int   ic;
    e = '{default: 0};
    e.int_cyc = -1;
    if (!en0) begin
      e.code   = 2'b11;
      e.st_cyc = 0;
      return e;
    end
    ic = 0;
    if (mask0) begin
      if (disable_at >= 0 && (unmask_at < 0 || disable_at <= unmask_at)) begin
        e.code   = 2'b11;
        e.st_cyc = disable_at + 1;
        return e;
      end
      ic = unmask_at + 1;
    end
    e.ints    = 1;
    e.int_cyc = ic;
    if ((rsent || rfail) && resp_at >= 1 && resp_at <= T - 1) begin
      e.code   = rfail ? 2'b01 : 2'b00;
      e.st_cyc = ic + resp_at + 1;
    end else begin
      e.code   = 2'b10;
      e.st_cyc = ic + T;
    end
    return e;
  endfunction

  // Drives one request through to the status handshake and records what the DUT did.
  task automatic do_irq(input logic [63:0] a, input logic [31:0] d, input bit en0,
                        input bit mask0, input int unmask_at, input int disable_at,
                        input int resp_at, input bit rsent, input bit rfail, input int hold,
                        output obs_t o);
    int c;
    o = '{default: 0};
    o.int_cyc = -1;
    o.st_cyc  = -1;
    o.addr_ok = 1'b1;
    o.stable  = 1'b1;
    cfg_interrupt_msix_enable = {1'b0, en0};
    cfg_interrupt_msix_mask   = {1'b0, mask0};
    s_axis_irq_addr  = a;
    s_axis_irq_data  = d;
    s_axis_irq_valid = 1'b1;
    for (int n = 0; n < 20 && s_axis_irq_ready !== 1'b1; n++) step();
    if (s_axis_irq_ready !== 1'b1) begin
      s_axis_irq_valid = 1'b0;
      return;
    end
    step();
    s_axis_irq_valid = 1'b0;
    s_axis_irq_addr  = {$urandom, $urandom};
    s_axis_irq_data  = $urandom;
    c = 0;
    while (c < 200) begin
      if (cfg_interrupt_msix_address !== a || cfg_interrupt_msix_data !== d) o.addr_ok = 1'b0;
      if (cfg_interrupt_msix_int === 1'b1) begin
        o.ints++;
        if (o.int_cyc < 0) begin
          o.int_cyc = c;
          o.a_seen  = cfg_interrupt_msix_address;
          o.d_seen  = cfg_interrupt_msix_data;
        end
      end
      if (m_axis_irq_status_valid === 1'b1) begin
        o.got_status = 1'b1;
        o.st_cyc     = c;
        o.code       = m_axis_irq_status;
        break;
      end
      if (c == unmask_at) cfg_interrupt_msix_mask = 2'b00;
      if (c == disable_at) cfg_interrupt_msix_enable = 2'b00;
      cfg_interrupt_msix_sent = rsent && o.int_cyc >= 0 && c == o.int_cyc + resp_at;
      cfg_interrupt_msix_fail = rfail && o.int_cyc >= 0 && c == o.int_cyc + resp_at;
      step();
      c++;
    end
    cfg_interrupt_msix_sent = 1'b0;
    cfg_interrupt_msix_fail = 1'b0;
    if (!o.got_status) return;
    for (int h = 0; h < hold; h++) begin
      step();
      if (cfg_interrupt_msix_int === 1'b1) o.ints++;
      if (m_axis_irq_status_valid !== 1'b1 || m_axis_irq_status !== o.code ||
          s_axis_irq_ready !== 1'b0) o.stable = 1'b0;
    end
    m_axis_irq_status_ready = 1'b1;
    step();
    m_axis_irq_status_ready = 1'b0;
    o.rdy_cyc = 0;
    while (s_axis_irq_ready !== 1'b1 && o.rdy_cyc < 5) begin
      step();
      o.rdy_cyc++;
    end
    if (cfg_interrupt_msix_int === 1'b1) o.ints++;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({s_axis_irq_ready, m_axis_irq_status, m_axis_irq_status_valid, cfg_interrupt_msix_int,
         cfg_interrupt_msi_function_number} !== 9'd0)
      $display("FAIL reset_ctrl: got %b want 0", {s_axis_irq_ready, m_axis_irq_status,
               m_axis_irq_status_valid, cfg_interrupt_msix_int, cfg_interrupt_msi_function_number});
    else n_pass++;
    n_checks++;
    if (cfg_interrupt_msix_address !== 64'd0 || cfg_interrupt_msix_data !== 32'd0)
      $display("FAIL reset_addr: got %h/%h want 0", cfg_interrupt_msix_address,
               cfg_interrupt_msix_data);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (s_axis_irq_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_axis_irq_ready);
    else n_pass++;
  endtask

  task automatic test_sent();
    obs_t o, e;
    do_irq(64'hFEE0_0000_0000_1000, 32'h0000_0041, 1, 0, -1, -1, 3, 1, 0, 0, o);
    e = ref_model(1, 0, -1, -1, 3, 1, 0);
    n_checks++;
    if (o.ints !== 1 || o.int_cyc !== e.int_cyc)
      $display("FAIL sent_int: got n=%0d at %0d want 1 at %0d", o.ints, o.int_cyc, e.int_cyc);
    else n_pass++;
    n_checks++;
    if (o.a_seen !== 64'hFEE0_0000_0000_1000 || o.d_seen !== 32'h41 || !o.addr_ok)
      $display("FAIL sent_addr: got %h/%h ok=%0d", o.a_seen, o.d_seen, o.addr_ok);
    else n_pass++;
    n_checks++;
    if (o.code !== e.code || o.st_cyc !== e.st_cyc)
      $display("FAIL sent_status: got %b at %0d want %b at %0d", o.code, o.st_cyc, e.code,
               e.st_cyc);
    else n_pass++;
    n_checks++;
    if (o.rdy_cyc !== 0) $display("FAIL sent_ready_return: got %0d want 0", o.rdy_cyc);
    else n_pass++;
  endtask

  task automatic test_fail();
    obs_t o, e;
    int   r;
    do_irq({$urandom, $urandom}, $urandom, 1, 0, -1, -1, 2, 0, 1, 0, o);
    e = ref_model(1, 0, -1, -1, 2, 0, 1);
    n_checks++;
    if (o.code !== e.code || o.st_cyc !== e.st_cyc)
      $display("FAIL fail_status: got %b at %0d want %b at %0d", o.code, o.st_cyc, e.code,
               e.st_cyc);
    else n_pass++;
    r = $urandom_range(1, T - 1);
    do_irq({$urandom, $urandom}, $urandom, 1, 0, -1, -1, r, 1, 1, 0, o);
    e = ref_model(1, 0, -1, -1, r, 1, 1);
    n_checks++;
    if (o.code !== e.code || o.st_cyc !== e.st_cyc)
      $display("FAIL fail_and_sent: got %b at %0d want %b at %0d", o.code, o.st_cyc, e.code,
               e.st_cyc);
    else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o, e;
    int   ra [3] = '{-1, 0, T - 1};
    for (int i = 0; i < 3; i++) begin
      do_irq({$urandom, $urandom}, $urandom, 1, 0, -1, -1, ra[i], ra[i] >= 0, 0, 0, o);
      e = ref_model(1, 0, -1, -1, ra[i], ra[i] >= 0, 0);
      n_checks++;
      if (o.code !== e.code || o.st_cyc !== e.st_cyc || o.ints !== 1)
        $display("FAIL timeout_%0d: got %b at %0d ints=%0d want %b at %0d ints=1", i, o.code,
                 o.st_cyc, o.ints, e.code, e.st_cyc);
      else n_pass++;
    end
  endtask

  task automatic test_disabled();
    obs_t o, e;
    do_irq({$urandom, $urandom}, $urandom, 0, 0, -1, -1, 1, 1, 0, 0, o);
    e = ref_model(0, 0, -1, -1, 1, 1, 0);
    n_checks++;
    if (o.code !== e.code || o.st_cyc !== e.st_cyc || o.ints !== 0)
      $display("FAIL disabled: got %b at %0d ints=%0d want %b at %0d ints=0", o.code, o.st_cyc,
               o.ints, e.code, e.st_cyc);
    else n_pass++;
  endtask

  task automatic test_masked();
    obs_t o, e;
    do_irq({$urandom, $urandom}, $urandom, 1, 1, 20, -1, 4, 1, 0, 0, o);
    e = ref_model(1, 1, 20, -1, 4, 1, 0);
    n_checks++;
    if (o.ints !== 1 || o.int_cyc !== e.int_cyc || o.code !== e.code || o.st_cyc !== e.st_cyc)
      $display("FAIL masked: got int %0d@%0d sts %b@%0d want 1@%0d sts %b@%0d", o.ints,
               o.int_cyc, o.code, o.st_cyc, e.int_cyc, e.code, e.st_cyc);
    else n_pass++;
    do_irq({$urandom, $urandom}, $urandom, 1, 1, -1, 5, 2, 1, 0, 0, o);
    e = ref_model(1, 1, -1, 5, 2, 1, 0);
    n_checks++;
    if (o.ints !== 0 || o.code !== e.code || o.st_cyc !== e.st_cyc)
      $display("FAIL disable_in_pend: got ints=%0d %b at %0d want 0 %b at %0d", o.ints, o.code,
               o.st_cyc, e.code, e.st_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    do_irq({$urandom, $urandom}, $urandom, 1, 0, -1, -1, 5, 0, 1, 10, o);
    e = ref_model(1, 0, -1, -1, 5, 0, 1);
    n_checks++;
    if (!o.stable || o.code !== e.code || o.ints !== 1)
      $display("FAIL backpressure: got stable=%0d %b ints=%0d want 1 %b 1", o.stable, o.code,
               o.ints, e.code);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    for (int i = 0; i < 8; i++) begin
      bit en0, mask0, rs, rf;
      int um, da, ra, k;
      en0   = ($urandom_range(0, 5) != 0);
      mask0 = ($urandom_range(0, 2) == 0);
      um    = mask0 ? int'($urandom_range(0, 8)) : -1;
      da    = (mask0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
      k     = $urandom_range(0, 3);
      rs    = k[0];
      rf    = k[1];
      ra    = $urandom_range(0, T + 2);
      do_irq({$urandom, $urandom}, $urandom, en0, mask0, um, da, ra, rs, rf,
             $urandom_range(0, 3), o);
      e = ref_model(en0, mask0, um, da, ra, rs, rf);
      n_checks++;
      if (!o.got_status || o.code !== e.code || o.st_cyc !== e.st_cyc || o.ints !== e.ints ||
          o.int_cyc !== e.int_cyc || !o.addr_ok || o.rdy_cyc !== 0)
        $display("FAIL b2b_%0d: got %b@%0d int %0d@%0d ok=%0d rdy=%0d want %b@%0d int %0d@%0d",
                 i, o.code, o.st_cyc, o.ints, o.int_cyc, o.addr_ok, o.rdy_cyc, e.code,
                 e.st_cyc, e.ints, e.int_cyc);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    bit   seen;
    cfg_interrupt_msix_enable = 2'b01;
    cfg_interrupt_msix_mask   = 2'b00;
    s_axis_irq_addr  = {$urandom, $urandom};
    s_axis_irq_data  = $urandom;
    s_axis_irq_valid = 1'b1;
    for (int n = 0; n < 20 && s_axis_irq_ready !== 1'b1; n++) step();
    step();
    s_axis_irq_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    cfg_interrupt_msix_sent = 1'b1;
    #1;
    n_checks++;
    if ({s_axis_irq_ready, m_axis_irq_status, m_axis_irq_status_valid, cfg_interrupt_msix_int,
         cfg_interrupt_msix_address, cfg_interrupt_msix_data} !== 101'd0)
      $display("FAIL reset_mid_outputs: got rdy=%b sts=%b v=%b int=%b a=%h d=%h want all 0",
               s_axis_irq_ready, m_axis_irq_status, m_axis_irq_status_valid,
               cfg_interrupt_msix_int, cfg_interrupt_msix_address, cfg_interrupt_msix_data);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m_axis_irq_status_valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    cfg_interrupt_msix_sent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m_axis_irq_status_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen || s_axis_irq_ready !== 1'b1)
      $display("FAIL reset_mid_after: got status_seen=%0d ready=%b want 0 1", seen,
               s_axis_irq_ready);
    else n_pass++;
    do_irq({$urandom, $urandom}, $urandom, 1, 0, -1, -1, 6, 1, 0, 0, o);
    e = ref_model(1, 0, -1, -1, 6, 1, 0);
    n_checks++;
    if (o.code !== e.code || o.st_cyc !== e.st_cyc || o.ints !== 1)
      $display("FAIL reset_mid_new_req: got %b at %0d ints=%0d want %b at %0d ints=1", o.code,
               o.st_cyc, o.ints, e.code, e.st_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sent();
    test_fail();
    test_timeout();
    test_disabled();
    test_masked();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
